// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe turn controller.
// Cell i of a 9-bit board vector is row i/3, column i%3.
package ttt_pkg;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    WAIT,
    COMMIT,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    ST_PLAY = 2'b00,
    ST_XWIN = 2'b01,
    ST_OWIN = 2'b10,
    ST_DRAW = 2'b11
  } status_t;

  // Three rows, three columns, then the two diagonals; index 0 is the top row.
  localparam logic [7:0][8:0] WIN_LINES = {
    9'h054, 9'h111, 9'h124, 9'h092, 9'h049, 9'h1C0, 9'h038, 9'h007
  };

  localparam logic [8:0] FULL_BOARD = 9'h1FF;

  function automatic logic has_line(input logic [8:0] board);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if ((board & WIN_LINES[i]) == WIN_LINES[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ttt_turn_controller_if.sv
// Bundle between the turn controller, its move sources and the board model.
// slave is the controller's view; master is the surrounding system's view.
interface ttt_turn_controller_if;

  logic       new_game;
  logic       x_is_ai;
  logic       o_is_ai;
  logic [8:0] h_move;
  logic       h_valid;
  logic [8:0] ai_move;
  logic       ai_valid;
  logic [8:0] X;
  logic [8:0] O;
  logic [8:0] C;
  logic       write_en;
  logic       board_reset;
  logic       ai_req;
  logic       ai_side;
  logic       turn;
  logic       reject;
  logic [1:0] status;
  logic       game_over;

  modport slave (
    input  new_game, x_is_ai, o_is_ai, h_move, h_valid, ai_move, ai_valid, X, O,
    output C, write_en, board_reset, ai_req, ai_side, turn, reject, status, game_over
  );

  modport master (
    output new_game, x_is_ai, o_is_ai, h_move, h_valid, ai_move, ai_valid, X, O,
    input  C, write_en, board_reset, ai_req, ai_side, turn, reject, status, game_over
  );

endinterface

// File: rtl/ttt_board_eval.sv
// Pure combinational view of the board: wins, full, lowest empty cell and
// legality of a candidate move (exactly one bit set, landing on an empty cell).
module ttt_board_eval
  import ttt_pkg::*;
(
  input  logic [8:0] x,
  input  logic [8:0] o,
  input  logic [8:0] move,
  output logic       x_win,
  output logic       o_win,
  output logic       full,
  output logic [8:0] lowest_empty,
  output logic       move_legal
);

  logic [8:0] occupied;
  logic [8:0] empty;

  assign occupied = x | o;
  assign empty    = ~occupied;

  assign x_win = has_line(x);
  assign o_win = has_line(o);
  assign full  = (occupied == FULL_BOARD);

  // Two's-complement trick isolates the least significant set bit.
  assign lowest_empty = empty & (~empty + 9'd1);

  assign move_legal = (move != '0) &&
                      ((move & (move - 9'd1)) == '0) &&
                      ((move & occupied) == '0);

endmodule

// File: rtl/ttt_turn_controller.sv
// Turn sequencer in front of the tic-tac-toe board: arbitrates human/AI moves,
// validates them, pulses the board write and scores the game after each commit.
module ttt_turn_controller
  import ttt_pkg::*;
#(
  parameter int AI_TIMEOUT    = 1024,
  parameter int SETTLE_CYCLES = 2,
  parameter int CLEAR_CYCLES  = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  ttt_turn_controller_if.slave bus
);

  localparam int AW = (AI_TIMEOUT > 1) ? $clog2(AI_TIMEOUT) : 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int CW = $clog2(CLEAR_CYCLES + 1);

  state_t          state_q,   state_d;
  status_t         status_q,  status_d;
  logic [CW-1:0]   clr_cnt_q, clr_cnt_d;
  logic [SW-1:0]   set_cnt_q, set_cnt_d;
  logic [AW-1:0]   ai_cnt_q,  ai_cnt_d;
  logic [8:0]      cell_q,    cell_d;
  logic            turn_q,    turn_d;
  logic            reject_q,  reject_d;
  logic            x_ai_q,    x_ai_d;
  logic            o_ai_q,    o_ai_d;
  logic            go_wait_q, go_wait_d;

  logic            side_ai;
  logic [8:0]      cand_move;
  logic            cand_valid;
  logic            x_win, o_win, full, move_legal;
  logic [8:0]      lowest_empty;

  // Only the source owning the side to move is ever looked at.
  assign side_ai    = turn_q ? o_ai_q : x_ai_q;
  assign cand_move  = side_ai ? bus.ai_move  : bus.h_move;
  assign cand_valid = side_ai ? bus.ai_valid : bus.h_valid;

  ttt_board_eval u_eval (
    .x            (bus.X),
    .o            (bus.O),
    .move         (cand_move),
    .x_win        (x_win),
    .o_win        (o_win),
    .full         (full),
    .lowest_empty (lowest_empty),
    .move_legal   (move_legal)
  );

  always_comb begin
    // NOTE: every next-state value starts as "hold", so no path can infer a latch.
    state_d   = state_q;
    status_d  = status_q;
    clr_cnt_d = clr_cnt_q;
    set_cnt_d = set_cnt_q;
    ai_cnt_d  = ai_cnt_q;
    cell_d    = cell_q;
    turn_d    = turn_q;
    reject_d  = 1'b0;
    x_ai_d    = x_ai_q;
    o_ai_d    = o_ai_q;
    go_wait_d = go_wait_q;

    if (bus.new_game) begin
      state_d   = CLEAR;
      clr_cnt_d = CW'(CLEAR_CYCLES - 1);
      cell_d    = '0;
      status_d  = ST_PLAY;
      x_ai_d    = bus.x_is_ai;
      o_ai_d    = bus.o_is_ai;
      go_wait_d = 1'b1;
    end else begin
      unique case (state_q)
        CLEAR: begin
          if (clr_cnt_q == '0) begin
            state_d  = go_wait_q ? WAIT : IDLE;
            turn_d   = 1'b0;
            status_d = ST_PLAY;
            ai_cnt_d = '0;
          end else begin
            clr_cnt_d = clr_cnt_q - CW'(1);
          end
        end
        IDLE: ;
        WAIT: begin
          if (side_ai) begin
            // An illegal AI move still ends the turn, with the fallback cell.
            if (cand_valid) begin
              state_d = COMMIT;
              if (move_legal) begin
                cell_d = cand_move;
              end else begin
                cell_d   = lowest_empty;
                reject_d = 1'b1;
              end
            end else if (ai_cnt_q == AW'(AI_TIMEOUT - 1)) begin
              state_d = COMMIT;
              cell_d  = lowest_empty;
            end else begin
              ai_cnt_d = ai_cnt_q + AW'(1);
            end
          end else if (cand_valid) begin
            if (move_legal) begin
              state_d = COMMIT;
              cell_d  = cand_move;
            end else begin
              reject_d = 1'b1;
            end
          end
        end
        COMMIT: begin
          state_d   = SETTLE;
          set_cnt_d = SW'(SETTLE_CYCLES - 1);
        end
        SETTLE: begin
          if (set_cnt_q == '0) state_d = CHECK;
          else                 set_cnt_d = set_cnt_q - SW'(1);
        end
        CHECK: begin
          if (x_win) begin
            status_d = ST_XWIN;
            state_d  = DONE;
          end else if (o_win) begin
            status_d = ST_OWIN;
            state_d  = DONE;
          end else if (full) begin
            status_d = ST_DRAW;
            state_d  = DONE;
          end else begin
            turn_d   = ~turn_q;
            state_d  = WAIT;
            ai_cnt_d = '0;
          end
        end
        DONE: ;
        default: state_d = CLEAR;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= CLEAR;
      status_q  <= ST_PLAY;
      clr_cnt_q <= CW'(CLEAR_CYCLES - 1);
      set_cnt_q <= '0;
      ai_cnt_q  <= '0;
      cell_q    <= '0;
      turn_q    <= 1'b0;
      reject_q  <= 1'b0;
      x_ai_q    <= 1'b0;
      o_ai_q    <= 1'b0;
      go_wait_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      status_q  <= status_d;
      clr_cnt_q <= clr_cnt_d;
      set_cnt_q <= set_cnt_d;
      ai_cnt_q  <= ai_cnt_d;
      cell_q    <= cell_d;
      turn_q    <= turn_d;
      reject_q  <= reject_d;
      x_ai_q    <= x_ai_d;
      o_ai_q    <= o_ai_d;
      go_wait_q <= go_wait_d;
    end
  end

  // State-decoded strobes drop as soon as reset forces CLEAR.
  assign bus.C           = cell_q;
  assign bus.write_en    = (state_q == COMMIT);
  assign bus.board_reset = (state_q == CLEAR);
  assign bus.ai_req      = (state_q == WAIT) && side_ai;
  assign bus.ai_side     = turn_q;
  assign bus.turn        = turn_q;
  assign bus.reject      = reject_q;
  assign bus.status      = status_q;
  assign bus.game_over   = (state_q == DONE);

endmodule
